usb_tx_block_sched: RTL and testbench
=====================================

# usb_tx_block_sched

Scheduler sitting in front of the PC-bound byte FIFO of the USB driver. It arbitrates between the camera pixel stream and an occasional 32-bit status word, and packs both into whole transfer blocks, padding with zeros where needed. It tracks how many complete blocks are buffered and drives the block-throttled pipe's ready flag. One complete 426×240 frame (102240 bytes) always ends on a block boundary.

## Interface
- BLOCK_BYTES, 1024: bytes per block-throttled transfer (power of two, ≥8).
- FRAME_BYTES, 102240: bytes per camera frame.
- FIFO_BYTES, 16384: tx FIFO capacity; credit counter saturates at FIFO_BYTES/BLOCK_BYTES.
- clk  in  1  system clock; all logic single-domain.
- rst  in  1  asynchronous, active-high reset.
- cam_valid  in  1  camera byte valid.
- cam_data  in  8  camera byte.
- cam_sof  in  1  qualifies first byte of a frame.
- cam_ready  out  1  camera byte accepted when cam_valid&&cam_ready.
- sts_req  in  1  status word pending (level, held until ack).
- sts_word  in  32  status payload.
- sts_ack  out  1  one-cycle pulse: sts_word latched.
- fifo_din  out  8  byte to tx FIFO (FIFO_tx_din).
- fifo_wr_en  out  1  write strobe (FIFO_tx_enable).
- fifo_full  in  1  tx FIFO full.
- blk_strobe  in  1  one-cycle pulse per block drained by host, already synchronised to clk.
- blk_ready  out  1  ≥1 complete block buffered (feeds FIFO_tx_ready via synchroniser).
- frame_done  out  1  one-cycle pulse when a frame's final (padded) block is complete.
- err  out  3  sticky: [0] credit underflow, [1] stray camera byte, [2] sof mid-frame.

## Operation
- States: IDLE, CAM, STS, PAD.
- IDLE: sts_req has priority → latch sts_word, pulse sts_ack, go STS. Else cam_valid&&cam_sof → go CAM (that byte is not consumed in IDLE). cam_valid without sof → cam_ready=1, byte discarded, err[1] set.
- CAM: cam_ready = !fifo_full; each accepted byte written immediately (fifo_din=cam_data). cam_sof on a non-first byte → byte written normally, err[2] set. After byte FRAME_BYTES is accepted → PAD, or → IDLE with frame_done if the block is already complete.
- STS: writes sts_word MSB first, 4 bytes, one per cycle while !fifo_full, then → PAD.
- PAD: writes 8'h00 while !fifo_full until the block byte counter wraps to 0, then → IDLE; frame_done pulses if PAD was entered from CAM.
- Block counter: clog2(BLOCK_BYTES) bits, +1 per write, wraps at BLOCK_BYTES. On wrap, the credit count is incremented.
- Credit count: +1 on block completion, −1 on blk_strobe. Both in the same cycle → unchanged. blk_strobe at 0 → stays 0, err[0] set. blk_ready = credits≠0.
- Frame counter: clog2(FRAME_BYTES+1) bits, cleared on entering CAM.
- Status is never inserted mid-frame. It waits for IDLE.

## Timing
- fifo_wr_en and fifo_din are combinational from state, fifo_full and the camera handshake: zero latency. fifo_wr_en is never high while fifo_full is high.
- Counters, credits, err, sts_ack and frame_done are registered. blk_ready rises the cycle after the completing write.
- IDLE→CAM costs one cycle. The sof byte is accepted in the first CAM cycle.
- STS path: 4 writes + (BLOCK_BYTES−4) pad writes = exactly one block.
- Reset values: state IDLE, all counters 0, cam_ready/sts_ack/fifo_wr_en/blk_ready/frame_done 0, err 3'b000.
- Reset mid-operation drops the partial block and all credits. The tx FIFO is reset by the same rst at top level.
- err bits clear only on rst.

## Structure
- Package usb_tx_pkg holds:
  - state enum;
  - PAD_BYTE=8'h00;
  - STS_BYTES=4;
  - error bit indices ERR_UNDERFLOW/ERR_STRAY/ERR_SOF.
- One sub-module, usb_blk_credit, contains:
  - saturating up/down credit counter;
  - underflow flag;
  - blk_ready generation.
- FSM and byte counters stay in the top module.

## Test plan
- BLOCK_BYTES=16, FRAME_BYTES=40, FIFO ready: stream 40 bytes 0x01..0x28 with sof on the first.
  - FIFO receives 40 bytes then 8×0x00.
  - frame_done pulses once.
  - credits=3, blk_ready=1.
- sts_req with 0xDEADBEEF in IDLE:
  - sts_ack one pulse;
  - FIFO gets DE AD BE EF + 12×0x00;
  - credits +1.
- sts_req raised mid-frame: no status byte appears until after the frame's pad. Then the status block follows.
- Hold fifo_full 5 cycles mid-frame: cam_ready=0 and fifo_wr_en=0 for those cycles, no byte lost or duplicated.
- blk_strobe and block completion in the same cycle at credits=1: credits stay 1. Then 2 strobes at credits=1 → credits 0, err[0]=1.
- Camera byte without sof in IDLE: consumed, not written, err[1]=1. Assert rst mid-frame: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB tx block scheduler.
package usb_tx_pkg;
    typedef enum logic [1:0] {IDLE, CAM, STS, PAD} state_t;

    localparam logic [7:0] PAD_BYTE = 8'h00;
    localparam int STS_BYTES = 4;

    localparam int ERR_UNDERFLOW = 0;
    localparam int ERR_STRAY     = 1;
    localparam int ERR_SOF       = 2;
endpackage

// File: rtl/usb_blk_credit.sv
// Saturating count of complete blocks sitting in the tx FIFO; drives the
// block-throttled pipe's ready flag and flags host drains with nothing buffered.
module usb_blk_credit #(
    parameter int MAX = 16,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          ready,
    output logic          underflow
);
    logic [CW-1:0] count_nxt;
    logic          underflow_nxt;

    always_comb begin
        count_nxt     = count;
        underflow_nxt = underflow;
        if (inc && !dec) begin
            if (count != CW'(MAX)) count_nxt = count + CW'(1);
        end else if (dec && !inc) begin
            if (count == '0) underflow_nxt = 1'b1;
            else             count_nxt     = count - CW'(1);
        end
    end

    // ready is registered from the next count so the synchroniser sees a clean flop output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            ready     <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            ready     <= (count_nxt != '0);
            underflow <= underflow_nxt;
        end
    end
endmodule

// File: rtl/usb_tx_block_sched.sv
// Packs camera frames and status words into whole zero-padded blocks for the
// PC-bound tx FIFO and tracks how many complete blocks are buffered.
module usb_tx_block_sched
    import usb_tx_pkg::*;
#(
    parameter int BLOCK_BYTES = 1024,
    parameter int FRAME_BYTES = 102240,
    parameter int FIFO_BYTES  = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cam_valid,
    input  logic [7:0]  cam_data,
    input  logic        cam_sof,
    output logic        cam_ready,
    input  logic        sts_req,
    input  logic [31:0] sts_word,
    output logic        sts_ack,
    output logic [7:0]  fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    input  logic        blk_strobe,
    output logic        blk_ready,
    output logic        frame_done,
    output logic [2:0]  err
);
    localparam int BW   = $clog2(BLOCK_BYTES);
    localparam int FW   = $clog2(FRAME_BYTES + 1);
    localparam int CMAX = FIFO_BYTES / BLOCK_BYTES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [BW-1:0] BLK_LAST = BW'(BLOCK_BYTES - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(FRAME_BYTES - 1);
    localparam logic [1:0]    STS_LAST = 2'(STS_BYTES - 1);

    state_t        state, state_nxt;
    logic [BW-1:0] blk_cnt;
    logic [FW-1:0] frm_cnt;
    logic [31:0]   sts_reg;
    logic [1:0]    sts_idx;
    logic          from_cam;
    logic          err_stray, err_sof;

    logic          blk_last, blk_wrap;
    logic          sts_take, cam_start, stray, sof_err, frame_fin;
    logic [CW-1:0] credits;
    logic          underflow;

    assign blk_last = (blk_cnt == BLK_LAST);
    assign blk_wrap = fifo_wr_en && blk_last;

    always_comb begin
        state_nxt  = state;
        cam_ready  = 1'b0;
        fifo_wr_en = 1'b0;
        fifo_din   = PAD_BYTE;
        sts_take   = 1'b0;
        cam_start  = 1'b0;
        stray      = 1'b0;
        sof_err    = 1'b0;
        frame_fin  = 1'b0;
        case (state)
            IDLE: begin
                // sof byte is left on the bus and taken in the first CAM cycle
                if (sts_req) begin
                    sts_take  = 1'b1;
                    state_nxt = STS;
                end else if (cam_valid && cam_sof) begin
                    cam_start = 1'b1;
                    state_nxt = CAM;
                end else if (cam_valid) begin
                    cam_ready = 1'b1;
                    stray     = 1'b1;
                end
            end
            CAM: begin
                cam_ready = !fifo_full;
                if (cam_valid && !fifo_full) begin
                    fifo_wr_en = 1'b1;
                    fifo_din   = cam_data;
                    sof_err    = cam_sof && (frm_cnt != '0);
                    if (frm_cnt == FRM_LAST) begin
                        if (blk_last) begin
                            state_nxt = IDLE;
                            frame_fin = 1'b1;
                        end else begin
                            state_nxt = PAD;
                        end
                    end
                end
            end
            STS: begin
                if (!fifo_full) begin
                    fifo_wr_en = 1'b1;
                    fifo_din   = sts_reg[31:24];
                    if (sts_idx == STS_LAST) state_nxt = PAD;
                end
            end
            PAD: begin
                if (!fifo_full) begin
                    fifo_wr_en = 1'b1;
                    if (blk_last) begin
                        state_nxt = IDLE;
                        frame_fin = from_cam;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            blk_cnt    <= '0;
            frm_cnt    <= '0;
            sts_reg    <= '0;
            sts_idx    <= '0;
            from_cam   <= 1'b0;
            sts_ack    <= 1'b0;
            frame_done <= 1'b0;
            err_stray  <= 1'b0;
            err_sof    <= 1'b0;
        end else begin
            state      <= state_nxt;
            sts_ack    <= sts_take;
            frame_done <= frame_fin;
            // block size is a power of two, so natural overflow is the wrap
            if (fifo_wr_en) blk_cnt <= blk_cnt + BW'(1);
            if (cam_start)
                frm_cnt <= '0;
            else if (state == CAM && fifo_wr_en)
                frm_cnt <= frm_cnt + FW'(1);
            if (sts_take) begin
                sts_reg <= sts_word;
                sts_idx <= '0;
            end else if (state == STS && fifo_wr_en) begin
                sts_reg <= {sts_reg[23:0], 8'h00};
                sts_idx <= sts_idx + 2'd1;
            end
            if (state_nxt == PAD && state != PAD) from_cam <= (state == CAM);
            if (stray)   err_stray <= 1'b1;
            if (sof_err) err_sof   <= 1'b1;
        end
    end

    usb_blk_credit #(.MAX(CMAX), .CW(CW)) u_credit (
        .clk       (clk),
        .rst       (rst),
        .inc       (blk_wrap),
        .dec       (blk_strobe),
        .count     (credits),
        .ready     (blk_ready),
        .underflow (underflow)
    );

    always_comb begin
        err                = '0;
        err[ERR_UNDERFLOW] = underflow;
        err[ERR_STRAY]     = err_stray;
        err[ERR_SOF]       = err_sof;
    end
endmodule

// File: tb/tb_usb_tx_block_sched.sv
// Directed bench: expected FIFO bytes are queued as stimulus is driven and
// popped as the scheduler writes them.
module tb_usb_tx_block_sched;
    localparam int BLOCK_BYTES = 16;
    localparam int FRAME_BYTES = 40;
    localparam int FIFO_BYTES  = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cam_valid = 1'b0;
    logic [7:0]  cam_data = '0;
    logic        cam_sof = 1'b0;
    logic        cam_ready;
    logic        sts_req = 1'b0;
    logic [31:0] sts_word = '0;
    logic        sts_ack;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full = 1'b0;
    logic        blk_strobe = 1'b0;
    logic        blk_ready;
    logic        frame_done;
    logic [2:0]  err;

    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    int fd_cnt = 0;
    int ack_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    usb_tx_block_sched #(
        .BLOCK_BYTES(BLOCK_BYTES), .FRAME_BYTES(FRAME_BYTES), .FIFO_BYTES(FIFO_BYTES)
    ) dut (
        .clk(clk), .rst(rst),
        .cam_valid(cam_valid), .cam_data(cam_data), .cam_sof(cam_sof), .cam_ready(cam_ready),
        .sts_req(sts_req), .sts_word(sts_word), .sts_ack(sts_ack),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .blk_strobe(blk_strobe), .blk_ready(blk_ready), .frame_done(frame_done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_wr_en) begin
                wr_total++;
                chk("wr_while_full", 32'(fifo_full), 32'd0);
                if (exp_q.size() == 0) chk("unexpected_write", 32'(fifo_din), 32'hFFFF_FFFF);
                else                   chk("fifo_din", 32'(fifo_din), 32'(exp_q.pop_front()));
            end
            if (frame_done) fd_cnt++;
            if (sts_ack)    ack_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic sof);
        int n = 0;
        cam_valid = 1'b1; cam_data = d; cam_sof = sof;
        do begin @(negedge clk); n++; end while (!cam_ready && n < 50);
        chk("cam_ready", 32'(cam_ready), 32'd1);
        @(posedge clk); #1;
        cam_valid = 1'b0; cam_sof = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
        for (int i = 0; i < BLOCK_BYTES - 4; i++) exp_q.push_back(8'h00);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic strobe();
        @(posedge clk); #1 blk_strobe = 1'b1;
        @(posedge clk); #1 blk_strobe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int w0;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cam_ready", 32'(cam_ready), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_blk_ready", 32'(blk_ready), 32'd0);
        chk("rst_sts_ack", 32'(sts_ack), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // full frame: 40 bytes then 8 pad bytes, 3 blocks
        for (int i = 0; i < FRAME_BYTES; i++) exp_q.push_back(8'(i + 1));
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < FRAME_BYTES; i++) send_byte(8'(i + 1), i == 0);
        drain();
        chk("f1_frame_done", 32'(fd_cnt), 32'd1);
        chk("f1_credits", 32'(dut.u_credit.count), 32'd3);
        chk("f1_blk_ready", 32'(blk_ready), 32'd1);
        chk("f1_err", 32'(err), 32'd0);

        // status word from IDLE
        push_word(32'hDEADBEEF);
        @(posedge clk); #1 sts_req = 1'b1; sts_word = 32'hDEADBEEF;
        n = 0;
        while (!sts_ack && n < 50) begin @(negedge clk); n++; end
        chk("s1_ack_seen", 32'(sts_ack), 32'd1);
        @(posedge clk); #1 sts_req = 1'b0;
        drain();
        chk("s1_ack_cnt", 32'(ack_cnt), 32'd1);
        chk("s1_credits", 32'(dut.u_credit.count), 32'd4);
        chk("s1_frame_done", 32'(fd_cnt), 32'd1);

        // status raised mid-frame, a 5-cycle fifo_full stall, and a stray sof
        for (int i = 0; i < FRAME_BYTES; i++) exp_q.push_back(8'(8'h40 + i));
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
        push_word(32'hCAFEF00D);
        for (int i = 0; i < FRAME_BYTES; i++) begin
            if (i == 10) begin sts_req = 1'b1; sts_word = 32'hCAFEF00D; end
            if (i == 20) begin
                cam_valid = 1'b1; cam_data = 8'(8'h40 + i); fifo_full = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_cam_ready", 32'(cam_ready), 32'd0);
                    chk("stall_wr_en", 32'(fifo_wr_en), 32'd0);
                end
                @(posedge clk); #1 fifo_full = 1'b0;
            end
            send_byte(8'(8'h40 + i), (i == 0) || (i == 29));
        end
        chk("f2_no_early_ack", 32'(ack_cnt), 32'd1);
        n = 0;
        while (!sts_ack && n < 100) begin @(negedge clk); n++; end
        chk("f2_ack_seen", 32'(sts_ack), 32'd1);
        @(posedge clk); #1 sts_req = 1'b0;
        drain();
        chk("f2_frame_done", 32'(fd_cnt), 32'd2);
        chk("f2_ack_cnt", 32'(ack_cnt), 32'd2);
        chk("f2_credits", 32'(dut.u_credit.count), 32'd8);
        chk("f2_err_sof", 32'(err), 32'b100);

        // bring credits to 1, then strobe during a block completion
        repeat (7) strobe();
        repeat (2) @(negedge clk);
        chk("c_credits_1", 32'(dut.u_credit.count), 32'd1);
        push_word(32'h12345678);
        w0 = wr_total;
        @(posedge clk); #1 sts_req = 1'b1; sts_word = 32'h12345678;
        n = 0;
        while (wr_total != w0 + BLOCK_BYTES - 1 && n < 100) begin
            @(posedge clk); #1;
            if (wr_total > w0) sts_req = 1'b0;
            n++;
        end
        chk("c_sync_writes", 32'(wr_total - w0), 32'(BLOCK_BYTES - 1));
        blk_strobe = 1'b1;
        @(posedge clk); #1 blk_strobe = 1'b0;
        drain();
        chk("c_same_cycle", 32'(dut.u_credit.count), 32'd1);
        chk("c_ack_cnt", 32'(ack_cnt), 32'd3);
        repeat (2) strobe();
        repeat (2) @(negedge clk);
        chk("c_credits_0", 32'(dut.u_credit.count), 32'd0);
        chk("c_blk_ready_0", 32'(blk_ready), 32'd0);
        chk("c_err_underflow", 32'(err), 32'b101);

        // stray camera byte in IDLE
        @(posedge clk); #1 cam_valid = 1'b1; cam_sof = 1'b0; cam_data = 8'h77;
        @(negedge clk);
        chk("stray_cam_ready", 32'(cam_ready), 32'd1);
        chk("stray_wr_en", 32'(fifo_wr_en), 32'd0);
        @(posedge clk); #1 cam_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_err", 32'(err), 32'b111);

        // asynchronous reset mid-frame
        for (int i = 0; i < 20; i++) exp_q.push_back(8'(8'h80 + i));
        for (int i = 0; i < 20; i++) send_byte(8'(8'h80 + i), i == 0);
        @(negedge clk);
        chk("pre_rst_blk_ready", 32'(blk_ready), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_cam_ready", 32'(cam_ready), 32'd0);
        chk("arst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("arst_blk_ready", 32'(blk_ready), 32'd0);
        chk("arst_sts_ack", 32'(sts_ack), 32'd0);
        chk("arst_frame_done", 32'(frame_done), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_credits", 32'(dut.u_credit.count), 32'd0);
        chk("arst_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
